// File: rtl/switch_entry_fifo_pkg.sv
// Shared constants for the key-entry path (switch capture on button press).
package switch_entry_fifo_pkg;

  localparam int unsigned SW_WIDTH       = 8;
  localparam int unsigned KEY_FIFO_DEPTH = 4;
  localparam int unsigned CLK_HZ         = 50_000_000;

endpackage : switch_entry_fifo_pkg

// File: rtl/switch_entry_fifo_entry_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module switch_entry_fifo_entry_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : switch_entry_fifo_entry_ram

// File: rtl/switch_entry_fifo.sv
// First-word-fall-through FIFO of switch values captured on each key press.
module switch_entry_fifo
  import switch_entry_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH,
  parameter int unsigned DEPTH = KEY_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           sw_in,
  input  logic                       pop,
  input  logic                       clear_ovf,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             pop_acc_c;
  logic             push_acc_c;
  logic             drop_c;
  logic             we_c;
  logic [WIDTH-1:0] rdata_c;

  // Acceptance, pointer, count and sticky-overflow next state.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    pop_acc_c  = pop & valid_q;
    push_acc_c = push & (~full_q | pop_acc_c);
    drop_c     = push & full_q & ~pop_acc_c;

    if (pop_acc_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_acc_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);

    // A drop in the same cycle as clear_ovf keeps the flag set.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end

    valid_d = (count_d != '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign we_c = push_acc_c & ~reset;

  switch_entry_fifo_entry_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_entry_ram (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (sw_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_c)
  );

  // Head is shown only when an entry exists so stale storage never leaks out.
  assign data_out = valid_q ? rdata_c : '0;
  assign valid    = valid_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule : switch_entry_fifo

// File: tb/tb_switch_entry_fifo.sv
// Directed self-checking bench for switch_entry_fifo (WIDTH=8, DEPTH=4).
module tb_switch_entry_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] sw_in;
  logic       pop;
  logic       clear_ovf;
  logic [7:0] data_out;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  switch_entry_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .sw_in     (sw_in),
    .pop       (pop),
    .clear_ovf (clear_ovf),
    .data_out  (data_out),
    .valid     (valid),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] v);
    push = 1'b1; sw_in = v;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  logic [7:0] a_vals [4];

  initial begin
    a_vals[0] = 8'hA1; a_vals[1] = 8'hA2; a_vals[2] = 8'hA3; a_vals[3] = 8'hA4;
    reset = 1'b1; push = 1'b1; sw_in = 8'hAA; pop = 1'b0; clear_ovf = 1'b0;
    #1;

    // 1: reset overrides push
    step(); step();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_data", 32'(data_out), 0);
    reset = 1'b0; push = 1'b0;

    // 2: three pushes then three pops in order
    do_push(8'h12);
    check_eq("t2_valid1", 32'(valid), 1);
    check_eq("t2_head1", 32'(data_out), 32'h12);
    do_push(8'h34);
    do_push(8'h56);
    check_eq("t2_count3", 32'(count), 3);
    check_eq("t2_pop12", 32'(data_out), 32'h12);
    do_pop();
    check_eq("t2_pop34", 32'(data_out), 32'h34);
    do_pop();
    check_eq("t2_pop56", 32'(data_out), 32'h56);
    do_pop();
    check_eq("t2_empty_valid", 32'(valid), 0);
    check_eq("t2_empty_data", 32'(data_out), 0);
    pop = 1'b1; step(); pop = 1'b0;
    check_eq("t2_pop_empty_count", 32'(count), 0);
    check_eq("t2_pop_empty_ovf", 32'(overflow), 0);

    // 3: fill, drop while full, clear; then set beats clear
    for (int i = 0; i < 4; i++) do_push(a_vals[i]);
    check_eq("t3_full", 32'(full), 1);
    check_eq("t3_count4", 32'(count), 4);
    do_push(8'hFF);
    check_eq("t3_ovf_set", 32'(overflow), 1);
    check_eq("t3_head_a1", 32'(data_out), 32'hA1);
    check_eq("t3_count_drop", 32'(count), 4);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    check_eq("t3_ovf_clr", 32'(overflow), 0);
    clear_ovf = 1'b1; push = 1'b1; sw_in = 8'hEE; step();
    clear_ovf = 1'b0; push = 1'b0;
    check_eq("t3_set_wins", 32'(overflow), 1);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    check_eq("t3_ovf_clr2", 32'(overflow), 0);

    // 4: push and pop together while full
    push = 1'b1; pop = 1'b1; sw_in = 8'h77; step();
    push = 1'b0; pop = 1'b0;
    check_eq("t4_count", 32'(count), 4);
    check_eq("t4_head_a2", 32'(data_out), 32'hA2);
    check_eq("t4_ovf", 32'(overflow), 0);
    check_eq("t4_rd_a2", 32'(data_out), 32'hA2); do_pop();
    check_eq("t4_rd_a3", 32'(data_out), 32'hA3); do_pop();
    check_eq("t4_rd_a4", 32'(data_out), 32'hA4); do_pop();
    check_eq("t4_rd_77", 32'(data_out), 32'h77); do_pop();
    check_eq("t4_empty", 32'(valid), 0);

    // 5: push and pop together while empty, then wrap the pointers
    push = 1'b1; pop = 1'b1; sw_in = 8'h80; step();
    check_eq("t5_count1", 32'(count), 1);
    check_eq("t5_head80", 32'(data_out), 32'h80);
    for (int i = 1; i <= 6; i++) begin
      sw_in = 8'(i);
      step();
      check_eq($sformatf("t5_pair%0d_head", i), 32'(data_out), 32'(i));
      check_eq($sformatf("t5_pair%0d_count", i), 32'(count), 1);
    end
    push = 1'b0; pop = 1'b0;

    // 6: reset with entries held
    do_push(8'h07);
    do_push(8'h08);
    check_eq("t6_count3", 32'(count), 3);
    reset = 1'b1; push = 1'b1; pop = 1'b1; sw_in = 8'h55; step();
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    check_eq("t6_rst_count", 32'(count), 0);
    check_eq("t6_rst_valid", 32'(valid), 0);
    do_push(8'h09);
    check_eq("t6_head09", 32'(data_out), 32'h09);
    check_eq("t6_count1", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_switch_entry_fifo
